eq_band_mixer: RTL

Final equalizer stage, directly upstream of the DAC transmitter. Takes three band-filtered signed samples (low/mid/high) and a per-band gain, and computes the weighted sum over multiple cycles with a single shared multiplier. Saturates the sum to 12 bits and converts it to offset binary. Presents the result on Data_Out with a one-cycle Rx_Listo strobe, which drives the DAC's Data_In/Rx_Listo pair.

---
 rtl/eq_band_mixer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/eq_band_mixer.sv
// Final equalizer stage: gain-weighted sum of three band samples through one
// shared multiplier, saturated to DATA_W bits and emitted as offset binary.
module eq_band_mixer #(
  parameter int DATA_W    = 12,
  parameter int GAIN_W    = 4,
  parameter int GAIN_FRAC = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid_In,
  input  logic [DATA_W-1:0] Band_Low,
  input  logic [DATA_W-1:0] Band_Mid,
  input  logic [DATA_W-1:0] Band_High,
  input  logic [GAIN_W-1:0] Gain_Low,
  input  logic [GAIN_W-1:0] Gain_Mid,
  input  logic [GAIN_W-1:0] Gain_High,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Rx_Listo,
  output logic              Busy,
  output logic              Overrun,
  output logic [2:0]        Dbg_State
);

  localparam int ACC_W  = DATA_W + GAIN_W + 2;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W-1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC_L = 3'd1,
    S_MAC_M = 3'd2,
    S_MAC_H = 3'd3,
    S_SAT   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [DATA_W-1:0]  r_band_low, r_band_mid, r_band_high;
  logic        [GAIN_W-1:0]  r_gain_low, r_gain_mid, r_gain_high;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [DATA_W-1:0]  r_data_out;
  logic                      r_rx_listo;
  logic                      r_busy;
  logic                      r_overrun;

  logic signed [DATA_W-1:0]  w_mul_a;
  logic signed [GAIN_W:0]    w_mul_g;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [ACC_W-1:0]   w_scaled;
  logic signed [DATA_W-1:0]  w_sat;
  logic        [DATA_W-1:0]  w_offset;
  logic                      w_accept;

  // Operand select for the single shared multiplier; gain is zero-extended.
  always_comb begin
    w_mul_a = r_band_high;
    w_mul_g = {1'b0, r_gain_high};
    case (r_state)
      S_MAC_L: begin w_mul_a = r_band_low; w_mul_g = {1'b0, r_gain_low}; end
      S_MAC_M: begin w_mul_a = r_band_mid; w_mul_g = {1'b0, r_gain_mid}; end
      default: ;
    endcase
  end

  assign w_prod     = w_mul_a * w_mul_g;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_sum  = (r_state == S_MAC_L) ? w_prod_ext : r_acc + w_prod_ext;
  assign w_scaled   = r_acc >>> GAIN_FRAC;

  always_comb begin
    w_sat = w_scaled[DATA_W-1:0];
    if (w_scaled > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_scaled < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
  end

  assign w_offset = {~w_sat[DATA_W-1], w_sat[DATA_W-2:0]};
  assign w_accept = Valid_In && (r_state == S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Valid_In) w_next = S_MAC_L;
      S_MAC_L: w_next = S_MAC_M;
      S_MAC_M: w_next = S_MAC_H;
      S_MAC_H: w_next = S_SAT;
      S_SAT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_band_low  <= '0;
      r_band_mid  <= '0;
      r_band_high <= '0;
      r_gain_low  <= '0;
      r_gain_mid  <= '0;
      r_gain_high <= '0;
      r_data_out  <= {1'b1, {(DATA_W-1){1'b0}}};
      r_rx_listo  <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      r_rx_listo <= (r_state == S_SAT);
      if (w_accept) begin
        r_band_low  <= Band_Low;
        r_band_mid  <= Band_Mid;
        r_band_high <= Band_High;
        r_gain_low  <= Gain_Low;
        r_gain_mid  <= Gain_Mid;
        r_gain_high <= Gain_High;
      end
      // A strobe arriving mid-computation is dropped but remembered.
      if (Valid_In && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (r_state == S_MAC_L || r_state == S_MAC_M || r_state == S_MAC_H)
        r_acc <= w_acc_sum;
      if (r_state == S_SAT) r_data_out <= w_offset;
    end
  end

  assign Data_Out  = r_data_out;
  assign Rx_Listo  = r_rx_listo;
  assign Busy      = r_busy;
  assign Overrun   = r_overrun;
  assign Dbg_State = r_state;

endmodule
